uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SAMPLE_RATE, default 24, giving rx_clk_en ticks per bit (even, >=8).
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 rx_clk_en  input  1  oversample tick, SAMPLE_RATE ticks per bit period.
REQ-006 rxd  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  8  last accepted byte.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 parity_err  output  1  one-clk pulse: parity mismatch.
REQ-012 overrun  output  1  one-clk pulse: new byte dropped because rx_valid was still set.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer (flops reset to 1); all decisions SHALL use the synchronized value.
REQ-014 State and sample counter SHALL advance only on cycles with rx_clk_en=1.
REQ-015 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: synchronized rxd=0 on a tick -> START, sample counter cleared to 0.
REQ-017 Sample counter SHALL count 0..SAMPLE_RATE-1 per bit and wrap to 0 entering the next bit.
REQ-018 Bit value SHALL be the 2-of-3 majority of samples at counts SAMPLE_RATE/2-1, SAMPLE_RATE/2, SAMPLE_RATE/2+1; decision is made at count SAMPLE_RATE/2+1.
REQ-019 START: majority 1 -> IDLE (glitch rejected, no flags); majority 0 -> DATA at bit end.
REQ-020 DATA: 8 bits, LSB first, shifted into a receive register; after bit 7 -> PARITY (macro) or STOP.
REQ-021 STOP: at the decision tick, return to IDLE immediately (no wait for bit end) so the next start edge is detected.
REQ-022 Stop majority 1 with no parity error: byte delivered; stop majority 0: byte discarded, frame_err pulsed.
REQ-023 Delivery: rx_data loaded and rx_valid set on the clock edge of the stop decision tick, visible next cycle.
REQ-024 rx_valid SHALL clear on the clock after rx_valid & rx_ready; rx_data SHALL hold until the next delivery.
REQ-025 Delivery with rx_valid=1 and rx_ready=0: new byte dropped, old rx_data kept, overrun pulsed.
REQ-026 Delivery in the same cycle as a handshake: new byte loaded, rx_valid stays 1, no overrun.
REQ-027 Frame error and parity error on the same frame SHALL both pulse; byte not delivered.
REQ-028 rx_clk_en low for any duration SHALL freeze the state and counter without error.

Reset
REQ-029 On rst=1 at a clk edge: state IDLE, counter 0, synchronizer 1s, rx_data 0x00, rx_valid 0, frame_err 0, parity_err 0, overrun 0.
REQ-030 rst mid-frame SHALL abort the frame with no flags; reception resumes at the next falling edge after rst is released.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state follows DATA, sampled per REQ-018, checked against PARITY_ODD; mismatch -> byte discarded, parity_err pulsed at the stop decision.
REQ-032 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is 8N1, parity_err tied to 0, PARITY_ODD ignored.

Verification
REQ-033 SAMPLE_RATE=24, rx_clk_en=1 always, 8N1 frame 0x55 (24 clks/bit), rx_ready=1 -> rx_valid for 1 clk, rx_data=0x55, no flags.
REQ-034 rxd low for 8 clks then high -> state returns to IDLE, no rx_valid, no flags.
REQ-035 Frame 0xA3 with stop bit held low -> frame_err one pulse, rx_valid stays 0, next frame 0x3C received correctly.
REQ-036 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, overrun pulse at the second stop decision; rx_ready=1 -> rx_valid clears.
REQ-037 Macro defined, PARITY_ODD=0, frame 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_data=0x07.
REQ-038 rst asserted for 1 clk during DATA bit 3 -> no rx_valid, no flags; following frame 0xF0 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 (8E1/8O1 with UART_RX_PARITY_EN), 2-of-3 mid-bit vote.
// Byte appears one clk after the stop decision tick; consumer backpressure via rx_ready, overflow drops the new byte.
module uart_rx #(
    parameter int SAMPLE_RATE = 24,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_clk_en,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CW = $clog2(SAMPLE_RATE);
    localparam logic [CW-1:0] C_LAST  = CW'(SAMPLE_RATE - 1);
    localparam logic [CW-1:0] C_MID_M = CW'(SAMPLE_RATE / 2 - 1);
    localparam logic [CW-1:0] C_MID   = CW'(SAMPLE_RATE / 2);
    localparam logic [CW-1:0] C_MID_P = CW'(SAMPLE_RATE / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_sync;
    logic          r_s0;
    logic          r_s1;
    logic [7:0]    r_shift;
    logic          r_par_bad;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_perr;
    logic          r_ovr;

    logic w_rxd;
    logic w_last;
    logic w_dec;
    logic w_maj;
    logic w_unused_par;

    assign w_rxd  = r_sync[1];
    assign w_last = (r_cnt == C_LAST);
    assign w_dec  = (r_cnt == C_MID_P);
    assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);

`ifdef UART_RX_PARITY_EN
    assign w_unused_par = 1'b0;
`else
    assign w_unused_par = PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_sync    <= 2'b11;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rxd};
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && rx_ready)
                r_valid <= 1'b0;

            if (rx_clk_en) begin
                if (r_state != S_IDLE)
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (r_cnt == C_MID_M)
                    r_s0 <= w_rxd;
                if (r_cnt == C_MID)
                    r_s1 <= w_rxd;

                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        if (!w_rxd)
                            r_state <= S_START;
                    end
                    S_START: begin
                        if (w_dec && w_maj) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else if (w_last) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                        end
                    end
                    S_DATA: begin
                        if (w_dec)
                            r_shift <= {w_maj, r_shift[7:1]};
                        if (w_last) begin
                            r_bit <= r_bit + 1'b1;
                            if (r_bit == 3'd7)
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_dec)
                            r_par_bad <= ((^r_shift) ^ w_maj) != PARITY_ODD;
                        if (w_last)
                            r_state <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        // Leave mid-bit so a start edge right after the stop bit is not missed
                        if (w_dec) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_ferr  <= !w_maj;
                            r_perr  <= r_par_bad;
                            if (w_maj && !r_par_bad) begin
                                if (r_valid && !rx_ready) begin
                                    r_ovr <= 1'b1;
                                end else begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven per oversample tick, expected events queued, monitor compares.
module tb_uart_rx;

    localparam int SR  = 24;
    localparam bit ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_clk_en;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  gaps   = 1'b0;

    uart_rx #(.SAMPLE_RATE(SR), .PARITY_ODD(ODD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_clk_en  (rx_clk_en),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic pop(input int kind, input int data, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event (data %0h), expected none", name, data);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            if (kind == K_DATA)
                chk({name, "_data"}, data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) pop(K_DATA, int'(rx_data), "rx_byte");
            if (frame_err)            pop(K_FERR, 0, "frame_err");
            if (parity_err)           pop(K_PERR, 0, "parity_err");
            if (overrun)              pop(K_OVR, 0, "overrun");
        end
    end

    task automatic push(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One oversample tick, optionally preceded by random stalled cycles
    task automatic tick();
        if (gaps)
            while ($urandom_range(0, 3) == 0) begin
                rx_clk_en = 1'b0;
                @(posedge clk); #1;
            end
        rx_clk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (SR) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit do_push);
        if (do_push) begin
            if (!stop_ok)            push(K_FERR, 0);
            if (!par_ok)             push(K_PERR, 0);
            if (stop_ok && par_ok)   push(K_DATA, int'(d));
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (HAS_PAR) send_bit((^d) ^ ODD ^ !par_ok);
        send_bit(stop_ok);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         s_ok;
        bit         p_ok;

        rst = 1'b1; rxd = 1'b1; rx_clk_en = 1'b0; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_parity_err", parity_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (4) tick();

        send_frame(8'h55, 1'b1, 1'b1, 1'b1);
        chk("byte55_data", rx_data, 8'h55);
        chk("byte55_q", exp_q.size(), 0);

        rxd = 1'b0;
        repeat (8) tick();
        rxd = 1'b1;
        repeat (3 * SR) tick();
        chk("glitch_q", exp_q.size(), 0);
        chk("glitch_valid", rx_valid, 1'b0);

        send_frame(8'hA3, 1'b0, 1'b1, 1'b1);
        chk("ferr_valid", rx_valid, 1'b0);
        chk("ferr_q", exp_q.size(), 0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        chk("after_ferr_data", rx_data, 8'h3C);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        chk("ovr_first_valid", rx_valid, 1'b1);
        chk("ovr_first_data", rx_data, 8'h11);
        push(K_OVR, 0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        chk("ovr_kept_data", rx_data, 8'h11);
        chk("ovr_kept_valid", rx_valid, 1'b1);
        chk("ovr_q", exp_q.size(), 0);
        push(K_DATA, 8'h11);
        rx_ready = 1'b1;
        tick();
        tick();
        chk("ovr_cleared_valid", rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        chk("perr_valid", rx_valid, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        chk("par_ok_data", rx_data, 8'h07);
`endif

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        repeat (SR / 2) tick();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rxd = 1'b1;
        repeat (2 * SR) tick();
        chk("midrst_q", exp_q.size(), 0);
        chk("midrst_valid", rx_valid, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
        chk("after_rst_data", rx_data, 8'hF0);

        gaps = 1'b1;
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            s_ok = ($urandom_range(0, 4) != 0);
            p_ok = HAS_PAR ? ($urandom_range(0, 4) != 0) : 1'b1;
            send_frame(d, s_ok, p_ok, 1'b1);
        end
        gaps = 1'b0;

        repeat (20) tick();
        chk("final_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
